// File: rtl/pipe_execute_if.sv
// Bundles the D/E-side execute inputs, downstream status/control, and the
// forwarding and E->M register outputs of the Y86-64 execute stage.
interface pipe_execute_if #(
    parameter int WIDTH = 64
);
    logic [2:0]       E_stat;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [WIDTH-1:0] E_valA;
    logic [WIDTH-1:0] E_valB;
    logic [WIDTH-1:0] E_valC;
    logic [3:0]       E_dstE;
    logic [3:0]       E_dstM;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;
    logic             M_stall;
    logic             M_bubble;

    logic [WIDTH-1:0] e_valE;
    logic             e_Cnd;
    logic [3:0]       e_dstE;
    logic             zf;
    logic             sf;
    logic             of;
    logic [2:0]       M_stat;
    logic [3:0]       M_icode;
    logic             M_Cnd;
    logic [WIDTH-1:0] M_valE;
    logic [WIDTH-1:0] M_valA;
    logic [3:0]       M_dstE;
    logic [3:0]       M_dstM;

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output m_stat, W_stat, M_stall, M_bubble,
        input  e_valE, e_Cnd, e_dstE, zf, sf, of,
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  m_stat, W_stat, M_stall, M_bubble,
        output e_valE, e_Cnd, e_dstE, zf, sf, of,
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/pipe_execute.sv
// Y86-64 pipelined execute stage: ALU, condition-code register with exception
// suppression, cmov/jXX condition evaluation and the E->M pipeline register.
module pipe_execute #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_execute_if.slave bus
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fun_e;

    typedef struct packed {
        logic [2:0]       stat;
        logic [3:0]       icode;
        logic             cnd;
        logic [WIDTH-1:0] val_e;
        logic [WIDTH-1:0] val_a;
        logic [3:0]       dst_e;
        logic [3:0]       dst_m;
    } m_reg_t;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [WIDTH-1:0] PLUS_EIGHT  = {{(WIDTH-4){1'b0}}, 4'b1000};
    localparam logic [WIDTH-1:0] MINUS_EIGHT = {{(WIDTH-4){1'b1}}, 4'b1000};

    localparam m_reg_t M_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        val_e: '0,
        val_a: '0,
        dst_e: R_NONE,
        dst_m: R_NONE
    };

    function automatic logic stat_exc(input logic [2:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_of;
    alu_fun_e         alu_fun;
    logic             is_opq;
    logic             opq_ok;
    logic             set_cc;
    logic             cond;
    logic             cnd_used;
    logic             cc_zf, cc_sf, cc_of;
    m_reg_t           m_q;
    m_reg_t           m_next;

    assign is_opq = (bus.E_icode == I_OPQ);
    assign opq_ok = (bus.E_ifun[3:2] == 2'b00);
    assign alu_fun = is_opq ? alu_fun_e'(bus.E_ifun[1:0]) : ALU_ADD;

    always_comb begin
        // NOTE: each combinational output is given a default first so no path leaves it unassigned (no latch).
        alu_a = '0;
        case (bus.E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = bus.E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valC;
            I_CALL, I_PUSHQ:              alu_a = MINUS_EIGHT;
            I_RET, I_POPQ:                alu_a = PLUS_EIGHT;
            default:                      ;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (bus.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = bus.E_valB;
            default: ;
        endcase
    end

    // Flags come from the result; the invalid OPq encodings produce zero and never update CC.
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        if (!is_opq || opq_ok) begin
            case (alu_fun)
                ALU_ADD: begin
                    alu_res = alu_b + alu_a;
                    alu_of  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                              (alu_res[WIDTH-1] != alu_b[WIDTH-1]);
                end
                ALU_SUB: begin
                    alu_res = alu_b - alu_a;
                    alu_of  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                              (alu_res[WIDTH-1] != alu_b[WIDTH-1]);
                end
                ALU_AND: alu_res = alu_b & alu_a;
                ALU_XOR: alu_res = alu_b ^ alu_a;
                default: ;
            endcase
        end
    end

    assign set_cc = is_opq && opq_ok && !stat_exc(bus.m_stat) &&
                    !stat_exc(bus.W_stat) && !bus.M_stall;

    // Conditions read the registered flags, i.e. those left by the previous OPq.
    always_comb begin
        cond = 1'b0;
        case (bus.E_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = (cc_sf ^ cc_of) | cc_zf;
            4'd2:    cond = cc_sf ^ cc_of;
            4'd3:    cond = cc_zf;
            4'd4:    cond = !cc_zf;
            4'd5:    cond = !(cc_sf ^ cc_of);
            4'd6:    cond = !(cc_sf ^ cc_of) && !cc_zf;
            default: cond = 1'b0;
        endcase
    end

    assign cnd_used   = (bus.E_icode == I_RRMOVQ) || (bus.E_icode == I_JXX);
    assign bus.e_Cnd  = cnd_used && cond;
    assign bus.e_valE = alu_res;
    assign bus.e_dstE = ((bus.E_icode == I_RRMOVQ) && !bus.e_Cnd) ? R_NONE : bus.E_dstE;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!rst_n) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (set_cc) begin
            cc_zf <= (alu_res == '0);
            cc_sf <= alu_res[WIDTH-1];
            cc_of <= alu_of;
        end
    end

    always_comb begin
        m_next       = M_BUBBLE;
        m_next.stat  = bus.E_stat;
        m_next.icode = bus.E_icode;
        m_next.cnd   = bus.e_Cnd;
        m_next.val_e = bus.e_valE;
        m_next.val_a = bus.E_valA;
        m_next.dst_e = bus.e_dstE;
        m_next.dst_m = bus.E_dstM;
    end

    // Stall outranks bubble, so asserting both holds the register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every state bit here is reset asynchronously; there is no memory array left unreset.
        if (!rst_n) begin
            m_q <= M_BUBBLE;
        end else if (!bus.M_stall) begin
            if (bus.M_bubble) begin
                m_q <= M_BUBBLE;
            end else begin
                m_q <= m_next;
            end
        end
    end

    assign bus.zf      = cc_zf;
    assign bus.sf      = cc_sf;
    assign bus.of      = cc_of;
    assign bus.M_stat  = m_q.stat;
    assign bus.M_icode = m_q.icode;
    assign bus.M_Cnd   = m_q.cnd;
    assign bus.M_valE  = m_q.val_e;
    assign bus.M_valA  = m_q.val_a;
    assign bus.M_dstE  = m_q.dst_e;
    assign bus.M_dstM  = m_q.dst_m;

endmodule
